// File: rtl/reg_store_unit_pkg.sv
// Shared definitions for the register store path.
//   - state_t   : store FSM encoding (IDLE=0, WRITE=1, DONE=2; 3 is unused and
//                 falls back to IDLE)
//   - DEF_*     : default data width, address width and write-timeout limit
//   - cnt_width : width of a counter that must reach (limit-1)
package reg_store_unit_pkg;

  localparam int DEF_SIZE    = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A counter only has to count up to limit-1, so $clog2(limit) bits suffice;
  // never return fewer than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/reg_store_unit_if.sv
// Bundle of decoder, register-file and data-memory signals around the store
// unit.
//   slave  modport : the store unit (takes request/register/ack inputs,
//                    drives the memory write port and status)
//   master modport : the surrounding decoder/memory side
// Signals:
//   iStoreReq, iSelB, iAddr[ADDR_W], iRegA[SIZE], iRegB[SIZE] : store request
//   oMemWrEn, oMemAddr[ADDR_W], oMemData[SIZE], iMemAck      : memory write
//   oBusy, oDone, oErr                                        : status
interface reg_store_unit_if
  import reg_store_unit_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              iStoreReq;
  logic              iSelB;
  logic [ADDR_W-1:0] iAddr;
  logic [SIZE-1:0]   iRegA;
  logic [SIZE-1:0]   iRegB;
  logic              oMemWrEn;
  logic [ADDR_W-1:0] oMemAddr;
  logic [SIZE-1:0]   oMemData;
  logic              iMemAck;
  logic              oBusy;
  logic              oDone;
  logic              oErr;

  modport slave (
    input  iStoreReq, iSelB, iAddr, iRegA, iRegB, iMemAck,
    output oMemWrEn, oMemAddr, oMemData, oBusy, oDone, oErr
  );

  modport master (
    output iStoreReq, iSelB, iAddr, iRegA, iRegB, iMemAck,
    input  oMemWrEn, oMemAddr, oMemData, oBusy, oDone, oErr
  );

endinterface

// File: rtl/reg_store_unit_hold_reg.sv
// store_hold_reg: enable-load register with asynchronous active-low clear.
// Captures the store data or address when a request is accepted and holds it
// for the whole memory transaction.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low clear
//   i_load  : load enable
//   i_d     : value to capture
//   o_q     : held value
module store_hold_reg #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_store_unit.sv
// reg_store_unit: store path from register A/B to data memory.
// A decoder request in IDLE latches the selected register and the address,
// the unit then holds a write strobe until memory acknowledges, and finally
// pulses oDone for one cycle. All outputs are registered.
// Optional feature macro: STORE_TIMEOUT_EN -- abort the write with oErr after
// TIMEOUT write cycles without acknowledge. Without it the write waits
// indefinitely and oErr stays 0.
// Ports:
//   Clock : clock, all state on the rising edge
//   Reset : asynchronous active-low reset
//   bus   : reg_store_unit_if.slave (request, register, memory and status)
module reg_store_unit
  import reg_store_unit_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             Clock,
  input  logic             Reset,
  reg_store_unit_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic [SIZE-1:0]   w_sel_data;
  logic [SIZE-1:0]   w_hold_data;
  logic [ADDR_W-1:0] w_hold_addr;
  logic              w_timeout;
  logic              w_wr_en_nx;
  logic              w_busy_nx;
  logic              w_done_nx;
  logic              w_err_nx;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  // A request is only honoured in IDLE; anything arriving while busy is dropped.
  assign w_load     = (r_state == ST_IDLE) && bus.iStoreReq;
  assign w_sel_data = bus.iSelB ? bus.iRegB : bus.iRegA;

  store_hold_reg #(.W(SIZE)) u_hold_data (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_load  (w_load),
    .i_d     (w_sel_data),
    .o_q     (w_hold_data)
  );

  store_hold_reg #(.W(ADDR_W)) u_hold_addr (
    .i_clk   (Clock),
    .i_rst_n (Reset),
    .i_load  (w_load),
    .i_d     (bus.iAddr),
    .o_q     (w_hold_addr)
  );

`ifdef STORE_TIMEOUT_EN
  localparam int               CNT_W     = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Counts unacknowledged WRITE cycles; cleared on the edge that enters WRITE.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WRITE) && !bus.iMemAck && (r_cnt != CNT_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An ack on the limit cycle wins: the timeout only fires without ack.
  assign w_timeout = (r_state == ST_WRITE) && !bus.iMemAck && (r_cnt == CNT_LIMIT);
`else
  assign w_timeout = 1'b0;
`endif

  // State register plus registered Moore outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= w_wr_en_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.iStoreReq) w_next = ST_WRITE;
      ST_WRITE: if (bus.iMemAck || w_timeout) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that the registered strobes
  // change on the same edge as the state itself.
  always_comb begin
    w_wr_en_nx = (w_next == ST_WRITE);
    w_busy_nx  = (w_next == ST_WRITE) || (w_next == ST_DONE);
    w_done_nx  = (w_next == ST_DONE);
    w_err_nx   = (w_next == ST_DONE) && w_timeout;
  end

  assign bus.oMemWrEn = r_wr_en;
  assign bus.oMemAddr = w_hold_addr;
  assign bus.oMemData = w_hold_data;
  assign bus.oBusy    = r_busy;
  assign bus.oDone    = r_done;
  assign bus.oErr     = r_err;

endmodule
